// File: rtl/spi_adapter_pkg.sv
// Shared definitions for the SPI master-side adapter: FSM states and header bit positions.
package spi_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT
  } state_t;

  // Outbound header bits
  function automatic int unsigned wrt_bit(input int unsigned nbits);
    return nbits - 1;
  endfunction

  function automatic int unsigned rd_bit(input int unsigned nbits);
    return nbits - 2;
  endfunction

  // Returned (minion) header bits
  function automatic int unsigned spc_bit(input int unsigned nbits);
    return nbits - 1;
  endfunction

  function automatic int unsigned val_bit(input int unsigned nbits);
    return nbits - 2;
  endfunction

endpackage

// File: rtl/spi_master_adapter_queue.sv
// vc_Queue: normal (non-bypass) FIFO with val/rdy ports and a free-entry count.
module vc_Queue #(
  parameter int unsigned nbits       = 8,
  parameter int unsigned num_entries = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enq_val,
  output logic                               enq_rdy,
  input  logic [nbits-1:0]                   enq_msg,
  output logic                               deq_val,
  input  logic                               deq_rdy,
  output logic [nbits-1:0]                   deq_msg,
  output logic [$clog2(num_entries+1)-1:0]   num_free_entries
);

  localparam int unsigned AW = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int unsigned CW = $clog2(num_entries + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(num_entries - 1);

  logic [nbits-1:0] mem [num_entries];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             do_enq;
  logic             do_deq;

  assign enq_rdy          = (count != CW'(num_entries));
  assign deq_val          = (count != '0);
  assign deq_msg          = mem[head];
  assign num_free_entries = CW'(num_entries) - count;
  assign do_enq           = enq_val & enq_rdy;
  assign do_deq           = deq_val & deq_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < num_entries; i++) mem[i] <= '0;
    end else begin
      if (do_enq) begin
        mem[tail] <= enq_msg;
        tail      <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (do_deq) head <= (head == LAST_PTR) ? '0 : head + 1'b1;
      unique case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_adapter.sv
// SPI master-side adapter: frames write payloads into SPI packets, polls the minion, buffers read data.
// Optional statistics counters enabled with `define SPI_MASTER_ADAPTER_STATS_EN.
module spi_master_adapter
  import spi_adapter_pkg::*;
#(
  parameter int unsigned nbits       = 8,
  parameter int unsigned rsp_entries = 2,
  parameter int unsigned poll_cycles = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [nbits-3:0]   recv_msg,
  input  logic               recv_val,
  output logic               recv_rdy,
  output logic [nbits-3:0]   send_msg,
  output logic               send_val,
  input  logic               send_rdy,
  output logic [nbits-1:0]   spi_send_msg,
  output logic               spi_send_val,
  input  logic               spi_send_rdy,
  input  logic [nbits-1:0]   spi_recv_msg,
  input  logic               spi_recv_val
`ifdef SPI_MASTER_ADAPTER_STATS_EN
  ,
  output logic [15:0]        stat_xfers,
  output logic [15:0]        stat_writes,
  output logic [15:0]        stat_reads,
  output logic [15:0]        stat_empty_polls
`endif
);

  localparam int unsigned PW      = nbits - 2;
  localparam int unsigned WRT_BIT = wrt_bit(nbits);
  localparam int unsigned RD_BIT  = rd_bit(nbits);
  localparam int unsigned SPC_BIT = spc_bit(nbits);
  localparam int unsigned VAL_BIT = val_bit(nbits);
  localparam int unsigned CW      = (poll_cycles > 1) ? $clog2(poll_cycles) : 1;
  localparam int unsigned FW      = $clog2(rsp_entries + 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(poll_cycles - 1);

  state_t           state;
  state_t           state_next;
  logic [nbits-1:0] pkt;
  logic [nbits-1:0] pkt_next;
  logic [CW-1:0]    poll_cnt;
  logic [CW-1:0]    poll_cnt_next;
  logic             minion_spc;
  logic             minion_spc_next;

  logic             wr;
  logic             rd;
  logic             issue;
  logic [PW-1:0]    payload;
  logic             ret_spc;
  logic             ret_val;
  logic [PW-1:0]    ret_data;
  logic             enq_val;
  logic             enq_rdy;
  logic [FW-1:0]    num_free;

  assign wr       = recv_val & minion_spc;
  assign rd       = (num_free != '0);
  assign issue    = wr | (poll_cnt == POLL_LAST);
  assign payload  = wr ? recv_msg : '0;
  assign ret_spc  = spi_recv_msg[SPC_BIT];
  assign ret_val  = spi_recv_msg[VAL_BIT];
  assign ret_data = spi_recv_msg[PW-1:0];

  assign spi_send_msg = pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pkt        <= '0;
      poll_cnt   <= '0;
      minion_spc <= 1'b0;
    end else begin
      state      <= state_next;
      pkt        <= pkt_next;
      poll_cnt   <= poll_cnt_next;
      minion_spc <= minion_spc_next;
    end
  end

  always_comb begin
    state_next      = state;
    pkt_next        = pkt;
    poll_cnt_next   = poll_cnt;
    minion_spc_next = minion_spc;
    recv_rdy        = 1'b0;
    spi_send_val    = 1'b0;
    enq_val         = 1'b0;
    unique case (state)
      IDLE: begin
        // Payload is framed in the same cycle it is accepted, so recv_rdy needs no storage behind it.
        recv_rdy = minion_spc;
        if (issue) begin
          pkt_next      = {wr, rd, payload};
          poll_cnt_next = '0;
          state_next    = XFER;
        end else begin
          // Reaching POLL_LAST always issues, so this increment saturates there.
          poll_cnt_next = poll_cnt + 1'b1;
        end
      end
      XFER: begin
        spi_send_val = 1'b1;
        if (spi_send_rdy) state_next = WAIT;
      end
      WAIT: begin
        if (spi_recv_val) begin
          minion_spc_next = ret_spc;
          enq_val         = pkt[RD_BIT] & ret_val;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  vc_Queue #(
    .nbits       (PW),
    .num_entries (rsp_entries)
  ) rsp_q (
    .clk              (clk),
    .reset            (reset),
    .enq_val          (enq_val),
    .enq_rdy          (enq_rdy),
    .enq_msg          (ret_data),
    .deq_val          (send_val),
    .deq_rdy          (send_rdy),
    .deq_msg          (send_msg),
    .num_free_entries (num_free)
  );

  // Read data is only legal when a read slot was reserved for it.
  assert property (@(posedge clk) disable iff (reset)
    (state == WAIT && spi_recv_val && ret_val) |-> pkt[RD_BIT]);

  assert property (@(posedge clk) disable iff (reset) enq_val |-> enq_rdy);

`ifdef SPI_MASTER_ADAPTER_STATS_EN
  logic done;
  assign done = (state == WAIT) & spi_recv_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_xfers       <= '0;
      stat_writes      <= '0;
      stat_reads       <= '0;
      stat_empty_polls <= '0;
    end else begin
      if (done)                   stat_xfers  <= stat_xfers + 1'b1;
      if (done & pkt[WRT_BIT])    stat_writes <= stat_writes + 1'b1;
      if (enq_val)                stat_reads  <= stat_reads + 1'b1;
      if (done & ~pkt[WRT_BIT] & ~ret_val) stat_empty_polls <= stat_empty_polls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_master_adapter.sv
// Directed bench for spi_master_adapter (nbits=8, rsp_entries=2, poll_cycles=16).
module tb_spi_master_adapter;

  logic       clk;
  logic       reset;
  logic [5:0] recv_msg;
  logic       recv_val;
  logic       recv_rdy;
  logic [5:0] send_msg;
  logic       send_val;
  logic       send_rdy;
  logic [7:0] spi_send_msg;
  logic       spi_send_val;
  logic       spi_send_rdy;
  logic [7:0] spi_recv_msg;
  logic       spi_recv_val;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  spi_master_adapter #(
    .nbits       (8),
    .rsp_entries (2),
    .poll_cycles (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .recv_msg     (recv_msg),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .send_msg     (send_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .spi_send_msg (spi_send_msg),
    .spi_send_val (spi_send_val),
    .spi_send_rdy (spi_send_rdy),
    .spi_recv_msg (spi_recv_msg),
    .spi_recv_val (spi_recv_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        drv_val;
    logic [5:0]  drv_msg;
    logic        srdy;
    logic        exp_rdy;
    int unsigned exp_lat;
    logic [7:0]  exp_pkt;
    logic [7:0]  ret;
    logic        exp_spc;
    logic        exp_sval;
    logic [5:0]  exp_smsg;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for the next outbound packet, then check its latency and contents.
  task automatic wait_pkt(input string name, input int unsigned exp_lat, input logic [7:0] exp_pkt);
    int unsigned lat;
    bit seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (spi_send_val) seen = 1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no spi_send_val within %0d cycles", name, lat);
    end else begin
      check({name, " latency"}, lat, exp_lat);
      check({name, " pkt"}, 32'(spi_send_msg), 32'(exp_pkt));
    end
  endtask

  // Stall once, handshake, idle in WAIT for a cycle, then return a packet.
  task automatic finish_xfer(input string name, input logic [7:0] exp_pkt, input logic [7:0] ret);
    tick();
    check({name, " stall val"}, 32'(spi_send_val), 32'd1);
    check({name, " stall pkt"}, 32'(spi_send_msg), 32'(exp_pkt));
    spi_send_rdy = 1'b1;
    tick();
    spi_send_rdy = 1'b0;
    #1;
    check({name, " wait val"}, 32'(spi_send_val), 32'd0);
    tick();
    spi_recv_msg = ret;
    spi_recv_val = 1'b1;
    tick();
    spi_recv_val = 1'b0;
    spi_recv_msg = 8'h00;
    #1;
  endtask

  task automatic run_row(input vec_t v, input int unsigned idx);
    string nm;
    nm = $sformatf("row%0d", idx);
    recv_val = v.drv_val;
    recv_msg = v.drv_msg;
    send_rdy = v.srdy;
    #1;
    check({nm, " recv_rdy"}, 32'(recv_rdy), 32'(v.exp_rdy));
    wait_pkt(nm, v.exp_lat, v.exp_pkt);
    if (v.exp_pkt[7]) recv_val = 1'b0;
    finish_xfer(nm, v.exp_pkt, v.ret);
    check({nm, " spc"}, 32'(recv_rdy), 32'(v.exp_spc));
    check({nm, " send_val"}, 32'(send_val), 32'(v.exp_sval));
    if (v.exp_sval) check({nm, " send_msg"}, 32'(send_msg), 32'(v.exp_smsg));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            drv  msg    srdy rdy lat pkt    ret    spc sval smsg
    vecs[0] = '{1'b0, 6'h00, 1'b1, 1'b0, 16, 8'h40, 8'h80, 1'b1, 1'b0, 6'h00};
    vecs[1] = '{1'b1, 6'h2A, 1'b1, 1'b1,  1, 8'hEA, 8'h80, 1'b1, 1'b0, 6'h00};
    vecs[2] = '{1'b1, 6'h15, 1'b1, 1'b1,  1, 8'hD5, 8'h00, 1'b0, 1'b0, 6'h00};
    vecs[3] = '{1'b1, 6'h15, 1'b1, 1'b0, 16, 8'h40, 8'h80, 1'b1, 1'b0, 6'h00};
    vecs[4] = '{1'b1, 6'h15, 1'b1, 1'b1,  1, 8'hD5, 8'h80, 1'b1, 1'b0, 6'h00};
    vecs[5] = '{1'b0, 6'h00, 1'b0, 1'b1, 16, 8'h40, 8'h7F, 1'b0, 1'b1, 6'h3F};
    vecs[6] = '{1'b0, 6'h00, 1'b1, 1'b0, 16, 8'h40, 8'h00, 1'b0, 1'b0, 6'h00};
    vecs[7] = '{1'b0, 6'h00, 1'b0, 1'b0, 16, 8'h40, 8'h4A, 1'b0, 1'b1, 6'h0A};
    vecs[8] = '{1'b0, 6'h00, 1'b0, 1'b0, 16, 8'h40, 8'hC5, 1'b1, 1'b1, 6'h0A};
    vecs[9] = '{1'b1, 6'h01, 1'b0, 1'b1,  1, 8'h81, 8'h80, 1'b1, 1'b1, 6'h0A};

    reset        = 1'b1;
    recv_msg     = 6'h00;
    recv_val     = 1'b0;
    send_rdy     = 1'b1;
    spi_send_rdy = 1'b0;
    spi_recv_msg = 8'h00;
    spi_recv_val = 1'b0;
    repeat (3) tick();

    check("reset recv_rdy", 32'(recv_rdy), 32'd0);
    check("reset spi_send_val", 32'(spi_send_val), 32'd0);
    check("reset spi_send_msg", 32'(spi_send_msg), 32'd0);
    check("reset send_val", 32'(send_val), 32'd0);
    check("reset send_msg", 32'(send_msg), 32'd0);
    reset = 1'b0;

    for (int unsigned i = 0; i < 10; i++) run_row(vecs[i], i);

    // Drain one buffered read; the second moves to the head.
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
    #1;
    check("drain send_val", 32'(send_val), 32'd1);
    check("drain send_msg", 32'(send_msg), 32'h05);

    // A returned packet outside WAIT must not touch minion_spc.
    spi_recv_msg = 8'h00;
    spi_recv_val = 1'b1;
    tick();
    spi_recv_val = 1'b0;
    #1;
    check("stray spc kept", 32'(recv_rdy), 32'd1);
    check("stray send_msg", 32'(send_msg), 32'h05);

    // Write into XFER, then reset while the engine stalls.
    recv_msg = 6'h33;
    recv_val = 1'b1;
    #1;
    check("pre-reset recv_rdy", 32'(recv_rdy), 32'd1);
    tick();
    recv_val = 1'b0;
    #1;
    check("pre-reset spi_send_val", 32'(spi_send_val), 32'd1);
    check("pre-reset pkt", 32'(spi_send_msg), 32'hF3);
    check("pre-reset send_val", 32'(send_val), 32'd1);

    reset = 1'b1;
    tick();
    check("mid reset spi_send_val", 32'(spi_send_val), 32'd0);
    check("mid reset send_val", 32'(send_val), 32'd0);
    check("mid reset recv_rdy", 32'(recv_rdy), 32'd0);
    check("mid reset spi_send_msg", 32'(spi_send_msg), 32'd0);
    reset = 1'b0;

    wait_pkt("post-reset poll", 16, 8'h40);
    finish_xfer("post-reset poll", 8'h40, 8'h00);
    check("post-reset spc", 32'(recv_rdy), 32'd0);
    check("post-reset send_val", 32'(send_val), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_adapter.md
Name: spi_master_adapter

Overview:
- Initiator-side counterpart of the SPI minion adapter.
- Takes (nbits-2)-bit write requests on a val/rdy interface and frames them into nbits-bit SPI packets with the header bits {val_wrt, val_rd}.
- Issues one packet at a time to an SPI master shift engine, decodes the returned minion header {spc, val} and delivers read data on a val/rdy response interface.
- Tracks minion queue space and polls the minion periodically when idle.

Parameters:
- nbits, 8, SPI packet width; payload is nbits-2.
- rsp_entries, 2, depth of the internal response buffer (>=1).
- poll_cycles, 16, idle cycles before an empty poll transaction is issued (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- recv_msg  input  nbits-2  write payload to minion
- recv_val  input  1  write payload valid
- recv_rdy  output  1  adapter accepts payload this cycle
- send_msg  output  nbits-2  read data from minion
- send_val  output  1  read data valid
- send_rdy  input  1  consumer ready
- spi_send_msg  output  nbits  packet to SPI master engine
- spi_send_val  output  1  packet valid
- spi_send_rdy  input  1  engine accepts packet
- spi_recv_msg  input  nbits  packet shifted back from minion
- spi_recv_val  input  1  returned packet valid (single-cycle pulse, always accepted)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Outbound packet format: [nbits-1] = val_wrt, [nbits-2] = val_rd, [nbits-3:0] = payload. Payload is 0 when val_wrt=0.
- Returned packet format: [nbits-1] = spc (minion can take a write), [nbits-2] = val (read data valid), [nbits-3:0] = data.
- FSM states: IDLE, XFER, WAIT. Reset to IDLE.
- Other reset values: minion_spc = 0, poll counter = 0, response buffer empty, all outputs 0.
- IDLE, issue condition: issue when (recv_val & minion_spc) or (poll counter == poll_cycles-1).
- IDLE, on issue:
  - val_wrt = recv_val & minion_spc.
  - val_rd = response buffer has >=1 free entry.
  - The packet register is loaded and the FSM moves to XFER.
  - Poll counter clears.
- IDLE, payload acceptance: recv_rdy = IDLE & minion_spc. The payload is consumed in the same cycle it is framed, so there is no separate request storage.
- IDLE, no issue: the poll counter increments, saturating at poll_cycles-1.
- XFER: spi_send_val = 1 and spi_send_msg = packet register, held stable until spi_send_rdy. On handshake, go to WAIT.
- WAIT: on spi_recv_val:
  - minion_spc <= spc bit.
  - If the issued val_rd=1 and the returned val=1, push the data into the response buffer.
  - If val=1 but val_rd=0, discard the data. This cannot legally happen; an assertion flags it.
  - Go to IDLE.
- No overflow: only one transaction is ever outstanding and val_rd requires free space, so the response buffer never overflows.
- spi_recv_val outside WAIT: ignored.
- Response side: send_* driven directly by the response buffer head. The buffer drains independently of the FSM.
- Write throughput: at most one write per SPI transaction. Back-to-back writes are possible only while each returned spc=1.
- Reset mid-transaction: state abandoned, FSM returns to IDLE, minion_spc=0, buffer cleared. The first post-reset transaction is a poll after poll_cycles idle cycles.
- Minimum latency: recv handshake to spi_send_val is 1 cycle.

Optional Feature:
- Macro: SPI_MASTER_ADAPTER_STATS_EN.
- When defined, adds output ports stat_xfers, stat_writes, stat_reads and stat_empty_polls, each 16 bits:
  - Counters clear on reset and wrap at 2^16.
  - stat_xfers increments on each completed transaction (spi_recv_val in WAIT).
  - stat_writes increments on each completed transaction with val_wrt=1.
  - stat_reads increments on each response push.
  - stat_empty_polls increments on a completed transaction with val_wrt=0 and returned val=0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package spi_adapter_pkg:
  - Bit-position constants WRT_BIT/RD_BIT (outbound) and SPC_BIT/VAL_BIT (returned), expressed relative to nbits.
  - Enum typedef for the FSM states IDLE/XFER/WAIT.
- Sub-module: the response buffer reuses the codebase's existing vc_Queue, instantiated with depth rsp_entries. Its num_free_entries output drives val_rd.

Test Plan:
- Reset, recv_val=0, no traffic → after 16 idle cycles spi_send_msg=8'h40 (poll, val_rd=1). Returned 8'h80 → minion_spc=1, send_val stays 0.
- Write path: minion_spc=1, recv_msg=6'h2A, recv_val=1 → recv_rdy=1; next cycle spi_send_msg=8'hEA. Returned 8'h80 → second write 6'h15 is accepted immediately.
- Back-pressure: returned 8'h00 (spc=0) → recv_rdy stays 0 with recv_val=1. The next poll returns 8'h80 → write 6'h15 proceeds as 8'hD5.
- Read path: poll returns 8'h7F (val=1, data 6'h3F) → send_msg=6'h3F, send_val=1 until send_rdy.
- Buffer full: send_rdy=0, two reads buffered (rsp_entries=2) → subsequent packets carry val_rd=0. A write of 6'h01 goes out as 8'h81.
- Mid-XFER reset with spi_send_rdy=0 → spi_send_val=0 on the next cycle, send_val=0, and the first new packet is a poll after 16 cycles.
